// File: rtl/load_stream_decoder.sv
// Receive side of the display-load serial stream: synchronises sclk/cs_n/ds/dc into clk,
// deserialises WORD_W-bit words and offers them on a valid/ready port with overrun tracking.
module load_stream_decoder #(
  parameter int WORD_W      = 12,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              ds_in,
  input  logic              dc_in,
  input  logic              word_ready,
  input  logic              clr_overrun,
  output logic [WORD_W-1:0] word_out,
  output logic              word_is_cmd,
  output logic              word_valid,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] ds_sync_r;
  logic [SYNC_STAGES-1:0] dc_sync_r;
  logic                   sclk_prev_r;
  logic                   sclk_s;
  logic                   cs_n_s;
  logic                   ds_s;
  logic                   dc_s;
  logic                   sclk_rise_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [WORD_W-1:0]      shreg_r;
  logic [WORD_W-1:0]      shift_next_s;
  logic                   done_r;
  logic                   done_cmd_r;
  logic                   accept_s;
  logic                   drop_s;

  // Input synchronisers plus one extra sclk stage for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      ds_sync_r   <= '0;
      dc_sync_r   <= '0;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_in};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n_in};
      ds_sync_r   <= {ds_sync_r[SYNC_STAGES-2:0], ds_in};
      dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], dc_in};
      sclk_prev_r <= sclk_s;
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_n_s      = cs_sync_r[SYNC_STAGES-1];
  assign ds_s        = ds_sync_r[SYNC_STAGES-1];
  assign dc_s        = dc_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;

  // Next shift-register value for the configured bit order
  always_comb begin
    shift_next_s = shreg_r;
    if (MSB_FIRST) begin
      shift_next_s = {shreg_r[WORD_W-2:0], ds_s};
    end else begin
      shift_next_s = {ds_s, shreg_r[WORD_W-1:1]};
    end
  end

  // Frame FSM: RESYNC waits out any frame already running when reset released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RESYNC;
      cnt_r      <= '0;
      shreg_r    <= '0;
      done_r     <= 1'b0;
      done_cmd_r <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        RESYNC: begin
          cnt_r <= '0;
          if (cs_n_s) state_r <= IDLE;
        end
        IDLE: begin
          cnt_r <= '0;
          if (!cs_n_s) state_r <= SHIFT;
        end
        SHIFT: begin
          if (cs_n_s) begin
            frame_err <= (cnt_r != '0);
            cnt_r     <= '0;
            state_r   <= IDLE;
          end else if (sclk_rise_s) begin
            shreg_r <= shift_next_s;
            if (cnt_r == CNT_W'(WORD_W - 1)) begin
              cnt_r      <= '0;
              done_r     <= 1'b1;
              done_cmd_r <= ~dc_s;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= RESYNC;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // A completed word sits in shreg_r for at least one sclk phase, so it is copied from there
  assign accept_s = word_valid & word_ready;
  assign drop_s   = done_r & word_valid & ~word_ready;

  // Output holding register, handshake and sticky overrun (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out    <= '0;
      word_is_cmd <= 1'b0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (done_r) begin
        if (!drop_s) begin
          word_out    <= shreg_r;
          word_is_cmd <= done_cmd_r;
          word_valid  <= 1'b1;
        end
      end else if (accept_s) begin
        word_valid <= 1'b0;
      end
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
